sram16_bridge: RTL and testbench

SRAM16_BRIDGE -- requirements
Module: sram16_bridge

---
 rtl/sram16_bridge.sv | 148 ++++++++++++++
 tb/tb_sram16_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram16_bridge.sv
// 32-bit SoC bus to 16-bit asynchronous SRAM bridge. Each word access is split
// into up to two big-endian halfword phases: a setup cycle, then WAIT_STATES+1 strobe cycles.
module sram16_bridge #(
  parameter int WAIT_STATES = 1
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_mem_sel,
  input  logic [29:0] I_mem_address,
  input  logic [3:0]  I_mem_byte_we,
  input  logic [31:0] I_mem_data_write,
  output logic [31:0] O_mem_data_read,
  output logic        O_mem_pause,
  output logic [19:0] O_sram_addr,
  output logic [15:0] O_sram_data_out,
  input  logic [15:0] I_sram_data_in,
  output logic        O_sram_data_oe,
  output logic        O_sram_ce_n,
  output logic        O_sram_oe_n,
  output logic        O_sram_we_n,
  output logic        O_sram_ub_n,
  output logic        O_sram_lb_n,
  output logic [1:0]  O_dbg_state
);

  // SoC handshake: I_mem_sel high in IDLE is a request. The SoC holds its bus
  // cycle while O_mem_pause is high; the first cycle with pause low completes it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_H0   = 2'd1,
    ST_H1   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_STROBE = 4'(WAIT_STATES);

  state_t      state;
  logic [3:0]  cnt;
  logic        strobe;
  logic [18:0] lat_addr;
  logic [3:0]  lat_we;
  logic [31:0] lat_wd;
  logic [15:0] rd_hi;
  logic        lat_write;
  logic        unused_addr_hi;

  assign lat_write      = |lat_we;
  assign unused_addr_hi = ^I_mem_address[29:19];
  assign O_dbg_state    = state;
  assign O_mem_pause    = ((state == ST_IDLE) && I_mem_sel) ||
                          (state == ST_H0) || (state == ST_H1);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      strobe          <= 1'b0;
      lat_addr        <= '0;
      lat_we          <= '0;
      lat_wd          <= '0;
      rd_hi           <= '0;
      O_mem_data_read <= '0;
      O_sram_addr     <= '0;
      O_sram_data_out <= '0;
      O_sram_data_oe  <= 1'b0;
      O_sram_ce_n     <= 1'b1;
      O_sram_oe_n     <= 1'b1;
      O_sram_we_n     <= 1'b1;
      O_sram_ub_n     <= 1'b1;
      O_sram_lb_n     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt            <= '0;
          strobe         <= 1'b0;
          O_sram_ce_n    <= 1'b1;
          O_sram_oe_n    <= 1'b1;
          O_sram_we_n    <= 1'b1;
          O_sram_ub_n    <= 1'b1;
          O_sram_lb_n    <= 1'b1;
          O_sram_data_oe <= 1'b0;
          if (I_mem_sel) begin
            lat_addr       <= I_mem_address[18:0];
            lat_we         <= I_mem_byte_we;
            lat_wd         <= I_mem_data_write;
            O_sram_ce_n    <= 1'b0;
            O_sram_data_oe <= |I_mem_byte_we;
            // A write touching only the low halfword starts directly in H1.
            if ((|I_mem_byte_we) && (I_mem_byte_we[3:2] == 2'b00)) begin
              state           <= ST_H1;
              O_sram_addr     <= {I_mem_address[18:0], 1'b1};
              O_sram_data_out <= I_mem_data_write[15:0];
              O_sram_ub_n     <= ~I_mem_byte_we[1];
              O_sram_lb_n     <= ~I_mem_byte_we[0];
            end else begin
              state           <= ST_H0;
              O_sram_addr     <= {I_mem_address[18:0], 1'b0};
              O_sram_data_out <= I_mem_data_write[31:16];
              O_sram_ub_n     <= (|I_mem_byte_we) & ~I_mem_byte_we[3];
              O_sram_lb_n     <= (|I_mem_byte_we) & ~I_mem_byte_we[2];
            end
          end
        end

        ST_H0, ST_H1: begin
          if (!strobe) begin
            strobe <= 1'b1;
            cnt    <= '0;
            if (lat_write) O_sram_we_n <= 1'b0;
            else           O_sram_oe_n <= 1'b0;
          end else if (cnt != LAST_STROBE) begin
            cnt <= cnt + 4'd1;
          end else begin
            strobe      <= 1'b0;
            cnt         <= '0;
            O_sram_oe_n <= 1'b1;
            O_sram_we_n <= 1'b1;
            if ((state == ST_H0) && (!lat_write || (lat_we[1:0] != 2'b00))) begin
              if (!lat_write) rd_hi <= I_sram_data_in;
              state           <= ST_H1;
              O_sram_addr     <= {lat_addr, 1'b1};
              O_sram_data_out <= lat_wd[15:0];
              O_sram_ub_n     <= lat_write & ~lat_we[1];
              O_sram_lb_n     <= lat_write & ~lat_we[0];
            end else begin
              // The read word is only published once both halves are in.
              if ((state == ST_H1) && !lat_write) O_mem_data_read <= {rd_hi, I_sram_data_in};
              state          <= ST_DONE;
              O_sram_ce_n    <= 1'b1;
              O_sram_data_oe <= 1'b0;
              O_sram_ub_n    <= 1'b1;
              O_sram_lb_n    <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram16_bridge.sv
// Bench for sram16_bridge: two instances (WAIT_STATES 0 and 1), each with its own
// behavioural SRAM, checked cycle by cycle against a phase-level reference model.
module tb_sram16_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic [29:0] addr_in;
  logic [3:0]  we_in;
  logic [31:0] wd_in;

  logic [31:0] rdata [2];
  logic [19:0] saddr [2];
  logic [15:0] sdout [2];
  logic [15:0] sdin  [2];
  logic [1:0]  dbg   [2];
  logic [1:0]  pause, doe, ce_n, oe_n, we_n, ub_n, lb_n;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sram16_bridge #(.WAIT_STATES(0)) dut0 (
    .I_clk(clk), .I_rst_n(rst_n), .I_mem_sel(sel[0]), .I_mem_address(addr_in),
    .I_mem_byte_we(we_in), .I_mem_data_write(wd_in), .O_mem_data_read(rdata[0]),
    .O_mem_pause(pause[0]), .O_sram_addr(saddr[0]), .O_sram_data_out(sdout[0]),
    .I_sram_data_in(sdin[0]), .O_sram_data_oe(doe[0]), .O_sram_ce_n(ce_n[0]),
    .O_sram_oe_n(oe_n[0]), .O_sram_we_n(we_n[0]), .O_sram_ub_n(ub_n[0]),
    .O_sram_lb_n(lb_n[0]), .O_dbg_state(dbg[0])
  );

  sram16_bridge #(.WAIT_STATES(1)) dut1 (
    .I_clk(clk), .I_rst_n(rst_n), .I_mem_sel(sel[1]), .I_mem_address(addr_in),
    .I_mem_byte_we(we_in), .I_mem_data_write(wd_in), .O_mem_data_read(rdata[1]),
    .O_mem_pause(pause[1]), .O_sram_addr(saddr[1]), .O_sram_data_out(sdout[1]),
    .I_sram_data_in(sdin[1]), .O_sram_data_oe(doe[1]), .O_sram_ce_n(ce_n[1]),
    .O_sram_oe_n(oe_n[1]), .O_sram_we_n(we_n[1]), .O_sram_ub_n(ub_n[1]),
    .O_sram_lb_n(lb_n[1]), .O_dbg_state(dbg[1])
  );

  // ---------------- SRAM device models (1K halfwords each) ----------------
  logic [15:0]   dev_mem [2][1024];
  logic [1023:0] dev_wr  [2];
  logic          mem_clear = 1'b0;

  function automatic logic [15:0] seed_val(input int i, input int a);
    if (a == 2) return 16'hDEAD;
    if (a == 3) return 16'hBEEF;
    return 16'(a * 40503 + i * 7919 + 12345);
  endfunction

  function automatic logic [15:0] dev_rd(input int i, input int a);
    return dev_wr[i][a] ? dev_mem[i][a] : seed_val(i, a);
  endfunction

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_v, input logic [15:0] new_v,
                                              input logic ub, input logic lb);
    return {ub ? old_v[15:8] : new_v[15:8], lb ? old_v[7:0] : new_v[7:0]};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_clear) begin
        dev_wr[i] <= '0;
      end else if (!ce_n[i] && !we_n[i] && doe[i]) begin
        dev_mem[i][saddr[i][9:0]] <= merge_bytes(dev_rd(i, int'(saddr[i][9:0])), sdout[i],
                                                 ub_n[i], lb_n[i]);
        dev_wr[i][saddr[i][9:0]]  <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sdin[i] = (!ce_n[i] && !oe_n[i]) ?
                (dev_wr[i][saddr[i][9:0]] ? dev_mem[i][saddr[i][9:0]] : seed_val(i, int'(saddr[i][9:0])))
                : 16'h5A5A;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [15:0] ref_mem [2][1024];
  logic [31:0] exp_rd  [2];
  logic [31:0] exp_q[$];

  task automatic init_models();
    mem_clear = 1'b1;
    @(posedge clk);
    #1 mem_clear = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 1024; a++) ref_mem[i][a] = seed_val(i, a);
  endtask

  // One SoC access on instance inst, checked cycle by cycle from the accept
  // cycle through DONE. hold keeps I_mem_sel high so the next call is back-to-back.
  task automatic do_access(input int inst, input logic [29:0] a, input logic [3:0] we,
                           input logic [31:0] wd, input bit hold, input string tag);
    int          ws, n_pause, exp_pause;
    int          ph_q[$];
    bit          wr, first;
    logic [9:0]  hw0, hw1;
    logic [31:0] prev_rd, exp_word;
    logic [6:0]  obs_ctl, exp_ctl;
    logic [4:0]  obs_done;
    logic [19:0] exp_addr;
    logic [15:0] exp_dout;
    logic        exp_oe_n, exp_we_n, exp_ub, exp_lb;
    ws  = (inst == 1) ? 1 : 0;
    wr  = (we != 4'b0000);
    hw0 = {a[8:0], 1'b0};
    hw1 = {a[8:0], 1'b1};
    if (!wr) begin
      ph_q.push_back(0);
      ph_q.push_back(1);
      exp_q.push_back({ref_mem[inst][hw0], ref_mem[inst][hw1]});
    end else begin
      if (we[3:2] != 2'b00) ph_q.push_back(0);
      if (we[1:0] != 2'b00) ph_q.push_back(1);
    end
    prev_rd = exp_rd[inst];

    @(negedge clk);
    sel[inst] = 1'b1;
    addr_in   = a;
    we_in     = we;
    wd_in     = wd;
    #1;
    tests_run++;
    if ({pause[inst], ce_n[inst], oe_n[inst], we_n[inst]} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL %s accept: pause/ce_n/oe_n/we_n got %b want 1111", tag,
               {pause[inst], ce_n[inst], oe_n[inst], we_n[inst]});
    end
    n_pause = pause[inst] ? 1 : 0;
    first   = 1'b1;

    foreach (ph_q[k]) begin
      for (int c = 0; c < ws + 2; c++) begin
        @(negedge clk);
        if (first) begin
          first = 1'b0;
          if (!hold) sel[inst] = 1'b0;
          addr_in = 30'($urandom);
          we_in   = 4'($urandom);
          wd_in   = $urandom;
        end
        #1;
        if (pause[inst]) n_pause++;
        exp_oe_n = !(!wr && c >= 1);
        exp_we_n = !(wr && c >= 1);
        exp_ub   = wr ? ~we[(ph_q[k] == 1) ? 1 : 3] : 1'b0;
        exp_lb   = wr ? ~we[(ph_q[k] == 1) ? 0 : 2] : 1'b0;
        exp_ctl  = {1'b0, exp_oe_n, exp_we_n, exp_ub, exp_lb, wr, 1'b1};
        obs_ctl  = {ce_n[inst], oe_n[inst], we_n[inst], ub_n[inst], lb_n[inst], doe[inst], pause[inst]};
        exp_addr = {a[18:0], (ph_q[k] == 1) ? 1'b1 : 1'b0};
        exp_dout = (ph_q[k] == 1) ? wd[15:0] : wd[31:16];
        tests_run++;
        if (obs_ctl !== exp_ctl) begin
          tests_failed++;
          $display("FAIL %s ctl ph%0d c%0d: ce/oe/we/ub/lb/oe/pause got %b want %b",
                   tag, ph_q[k], c, obs_ctl, exp_ctl);
        end
        tests_run++;
        if (saddr[inst] !== exp_addr) begin
          tests_failed++;
          $display("FAIL %s addr ph%0d c%0d: got %h want %h", tag, ph_q[k], c, saddr[inst], exp_addr);
        end
        if (wr) begin
          tests_run++;
          if (sdout[inst] !== exp_dout) begin
            tests_failed++;
            $display("FAIL %s dout ph%0d c%0d: got %h want %h", tag, ph_q[k], c, sdout[inst], exp_dout);
          end
        end
        tests_run++;
        if (rdata[inst] !== prev_rd) begin
          tests_failed++;
          $display("FAIL %s rdata_hold ph%0d c%0d: got %h want %h", tag, ph_q[k], c, rdata[inst], prev_rd);
        end
      end
    end

    @(negedge clk);
    #1;
    obs_done = {ce_n[inst], oe_n[inst], we_n[inst], doe[inst], pause[inst]};
    tests_run++;
    if (obs_done !== 5'b11100) begin
      tests_failed++;
      $display("FAIL %s done_ctl: ce/oe/we/data_oe/pause got %b want 11100", tag, obs_done);
    end
    exp_word = wr ? prev_rd : exp_q.pop_front();
    tests_run++;
    if (rdata[inst] !== exp_word) begin
      tests_failed++;
      $display("FAIL %s rdata: got %h want %h", tag, rdata[inst], exp_word);
    end
    exp_rd[inst] = exp_word;
    exp_pause    = 1 + ph_q.size() * (ws + 2);
    tests_run++;
    if (n_pause != exp_pause) begin
      tests_failed++;
      $display("FAIL %s pause_cycles: got %0d want %0d", tag, n_pause, exp_pause);
    end

    if (wr) begin
      if (we[3]) ref_mem[inst][hw0][15:8] = wd[31:24];
      if (we[2]) ref_mem[inst][hw0][7:0]  = wd[23:16];
      if (we[1]) ref_mem[inst][hw1][15:8] = wd[15:8];
      if (we[0]) ref_mem[inst][hw1][7:0]  = wd[7:0];
      tests_run++;
      if ({dev_rd(inst, int'(hw0)), dev_rd(inst, int'(hw1))} !== {ref_mem[inst][hw0], ref_mem[inst][hw1]}) begin
        tests_failed++;
        $display("FAIL %s sram_content: got %h want %h", tag,
                 {dev_rd(inst, int'(hw0)), dev_rd(inst, int'(hw1))}, {ref_mem[inst][hw0], ref_mem[inst][hw1]});
      end
    end
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i], doe[i], pause[i]} !== 7'b1111100) begin
        tests_failed++;
        $display("FAIL %s idle inst%0d: ce/oe/we/ub/lb/data_oe/pause got %b want 1111100", tag, i,
                 {ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i], doe[i], pause[i]});
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n   = 1'b0;
    sel     = 2'b00;
    addr_in = '0;
    we_in   = '0;
    wd_in   = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    init_models();
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({rdata[i], saddr[i], sdout[i]} !== 68'h0) begin
        tests_failed++;
        $display("FAIL reset regs inst%0d: rdata=%h addr=%h dout=%h want all zero", i, rdata[i], saddr[i], sdout[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_idle("idle_nosel");
    end
  endtask

  task automatic test_directed();
    do_access(1, 30'h0000_0001, 4'b0000, 32'h0, 1'b0, "rd_ws1");
    tests_run++;
    if (rdata[1] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rd_ws1 word: got %h want deadbeef", rdata[1]);
    end
    do_access(1, 30'h0000_0010, 4'b1111, 32'h12345678, 1'b0, "wr_full");
    tests_run++;
    if ({dev_rd(1, 'h20), dev_rd(1, 'h21)} !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL wr_full sram: got %h want 12345678", {dev_rd(1, 'h20), dev_rd(1, 'h21)});
    end
    do_access(1, 30'h0000_0000, 4'b0001, 32'h000000AB, 1'b0, "wr_byte0");
    do_access(1, 30'h0000_0010, 4'b0000, 32'h0, 1'b0, "rd_back");
    do_access(0, 30'h0000_0001, 4'b0000, 32'h0, 1'b0, "rd_ws0");
    tests_run++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rd_ws0 word: got %h want deadbeef", rdata[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_access(1, 30'h0000_0001, 4'b0000, 32'h0, 1'b1, "b2b_rd1");
    do_access(1, 30'h0000_0010, 4'b0000, 32'h0, 1'b1, "b2b_rd2");
    do_access(1, 30'h0000_0022, 4'b1100, 32'hCAFE0000, 1'b1, "b2b_wr");
    do_access(1, 30'h0000_0022, 4'b0000, 32'h0, 1'b0, "b2b_rd3");
    do_access(0, 30'h0000_0033, 4'b0110, 32'h00A5C300, 1'b1, "b2b0_wr");
    do_access(0, 30'h0000_0033, 4'b0000, 32'h0, 1'b0, "b2b0_rd");
  endtask

  task automatic test_random();
    int       cur, nxt;
    bit       hold;
    logic [3:0] we;
    nxt = $urandom_range(0, 1);
    for (int n = 0; n < 40; n++) begin
      cur  = nxt;
      nxt  = $urandom_range(0, 1);
      hold = (cur == nxt) && (n < 39) && ($urandom_range(0, 2) == 0);
      we   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      do_access(cur, 30'($urandom), we, $urandom, hold, $sformatf("rnd%0d", n));
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    sel[1]  = 1'b1;
    addr_in = 30'h0000_0044;
    we_in   = 4'b1111;
    wd_in   = $urandom;
    @(negedge clk);
    sel[1] = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if ({we_n[1], doe[1]} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rst_mid precondition: we_n/data_oe got %b want 01", {we_n[1], doe[1]});
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({we_n[1], ce_n[1], doe[1], pause[1]} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL rst_mid async: we_n/ce_n/data_oe/pause got %b want 1100",
               {we_n[1], ce_n[1], doe[1], pause[1]});
    end
    tests_run++;
    if ({rdata[0], rdata[1], saddr[1], sdout[1]} !== 100'h0) begin
      tests_failed++;
      $display("FAIL rst_mid regs: rdata0=%h rdata1=%h addr=%h dout=%h want zero",
               rdata[0], rdata[1], saddr[1], sdout[1]);
    end
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_idle("post_reset");
    end
    init_models();
    do_access(1, 30'h0000_0001, 4'b0000, 32'h0, 1'b0, "first_after_rst1");
    do_access(0, 30'h0000_0005, 4'b0011, 32'h0000_7E81, 1'b0, "first_after_rst0");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
